// File: rtl/ps2_keycode_receiver_pkg.sv
// PS/2 scan-code set 2 constants, receiver defaults and frame states.
// Shared by the keycode receiver and the game state machine.
package ps2_keycode_receiver_pkg;

   localparam int FILTER_LEN_DEF     = 8;
   localparam int TIMEOUT_CYCLES_DEF = 25000;
   localparam int STROBE_LEN_DEF     = 1;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_ESC   = 8'h76;
   localparam logic [7:0] PS2_S     = 8'h1B;
   localparam logic [7:0] PS2_P     = 8'h4D;
   localparam logic [7:0] PS2_R     = 8'h2D;
   localparam logic [7:0] PS2_UP    = 8'h75;
   localparam logic [7:0] PS2_RIGHT = 8'h74;
   localparam logic [7:0] PS2_DOWN  = 8'h72;
   localparam logic [7:0] PS2_LEFT  = 8'h6B;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Odd parity over data+parity, and the stop bit must be high.
   function automatic logic frame_ok(input logic [7:0] dat, input logic par, input logic stop);
      return stop & (^{dat, par});
   endfunction

endpackage

// File: rtl/ps2_keycode_receiver_if.sv
// Decoded key output bundle: master is the receiver, slave is the consumer (game FSM).
interface ps2_keycode_receiver_if;
   logic [7:0] keycode;
   logic       new_key_strobe;
   logic       extended;
   logic       frame_err;

   modport master (output keycode, output new_key_strobe, output extended, output frame_err);
   modport slave  (input  keycode, input  new_key_strobe, input  extended, input  frame_err);
endinterface

// File: rtl/ps2_keycode_receiver_line_filter.sv
// Two-flop sync + FILTER_LEN glitch filter for the async ps2_clk line; fall is a registered
// one-cycle pulse on the filtered 1->0 transition. Latency 2 + FILTER_LEN + 1 cycles, no backpressure.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_25MHz,
   input  logic rst_n,
   input  logic line_in,
   output logic fall
);

   logic [1:0]            sync_q;
   logic [FILTER_LEN-1:0] shreg_q;
   logic                  filt_q;
   logic                  filt_nxt;

   // Level only moves once the whole window agrees; anything in between holds.
   always_comb begin
      filt_nxt = filt_q;
      if (&shreg_q)
         filt_nxt = 1'b1;
      else if (shreg_q == '0)
         filt_nxt = 1'b0;
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         shreg_q <= '1;
         filt_q  <= 1'b1;
         fall    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], line_in};
         shreg_q <= {shreg_q[FILTER_LEN-2:0], sync_q[1]};
         filt_q  <= filt_nxt;
         fall    <= filt_q & ~filt_nxt;
      end
   end

endmodule

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: frame FSM, timeout, E0/F0 prefix decode and make-code strobe.
// keycode/strobe move two cycles after the registered clock fall that ends a frame; no backpressure.
module ps2_keycode_receiver
   import ps2_keycode_receiver_pkg::*;
#(
   parameter int FILTER_LEN     = FILTER_LEN_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int STROBE_LEN     = STROBE_LEN_DEF
) (
   input  logic                          clk_25MHz,
   input  logic                          rst_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   ps2_keycode_receiver_if.master        key_if
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES);
   localparam int            SW       = $clog2(STROBE_LEN + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] STB_LOAD = SW'(STROBE_LEN);

   logic            clk_fall;
   logic [1:0]      data_sync_q;
   logic            data_s;

   rx_state_t       state_q, state_nxt;
   logic [2:0]      bit_cnt_q, bit_cnt_nxt;
   logic [7:0]      shift_q, shift_nxt;
   logic            par_q, par_nxt;
   logic            byte_vld_q, byte_vld_nxt;
   logic            err_q, err_nxt;
   logic [TW-1:0]   tmo_q;

   logic            ext_q, brk_q;
   logic [7:0]      keycode_q;
   logic            extended_q;
   logic [SW-1:0]   strobe_q;
   logic            make_key;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk_25MHz (clk_25MHz),
      .rst_n     (rst_n),
      .line_in   (ps2_clk),
      .fall      (clk_fall)
   );

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n)
         data_sync_q <= 2'b11;
      else
         data_sync_q <= {data_sync_q[0], ps2_data};
   end
   assign data_s = data_sync_q[1];

   // Frame FSM: steps only on a filtered clock fall; a stalled frame is aborted by the timeout.
   always_comb begin
      state_nxt    = state_q;
      bit_cnt_nxt  = bit_cnt_q;
      shift_nxt    = shift_q;
      par_nxt      = par_q;
      byte_vld_nxt = 1'b0;
      err_nxt      = 1'b0;
      if (clk_fall) begin
         case (state_q)
            RX_IDLE: begin
               if (!data_s) begin
                  state_nxt   = RX_DATA;
                  bit_cnt_nxt = 3'd0;
               end
            end
            RX_DATA: begin
               shift_nxt   = {data_s, shift_q[7:1]};
               bit_cnt_nxt = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7)
                  state_nxt = RX_PARITY;
            end
            RX_PARITY: begin
               par_nxt   = data_s;
               state_nxt = RX_STOP;
            end
            RX_STOP: begin
               if (frame_ok(shift_q, par_q, data_s))
                  byte_vld_nxt = 1'b1;
               else
                  err_nxt = 1'b1;
               state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
         endcase
      end else if (state_q != RX_IDLE && tmo_q == TMO_LAST) begin
         state_nxt = RX_IDLE;
         err_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RX_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         par_q      <= 1'b0;
         byte_vld_q <= 1'b0;
         err_q      <= 1'b0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_nxt;
         bit_cnt_q  <= bit_cnt_nxt;
         shift_q    <= shift_nxt;
         par_q      <= par_nxt;
         byte_vld_q <= byte_vld_nxt;
         err_q      <= err_nxt;
         if (state_q == RX_IDLE || clk_fall)
            tmo_q <= '0;
         else
            tmo_q <= tmo_q + TW'(1);
      end
   end

   // shift_q holds the completed byte while byte_vld_q is high; the FSM sits in IDLE then.
   assign make_key = byte_vld_q && (shift_q != PS2_EXT) && (shift_q != PS2_BRK) && !brk_q;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         keycode_q  <= 8'h00;
         extended_q <= 1'b0;
         strobe_q   <= '0;
      end else begin
         if (err_q) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (byte_vld_q) begin
            if (shift_q == PS2_EXT) begin
               ext_q <= 1'b1;
            end else if (shift_q == PS2_BRK) begin
               brk_q <= 1'b1;
            end else if (brk_q) begin
               brk_q <= 1'b0;
               ext_q <= 1'b0;
            end else begin
               keycode_q  <= shift_q;
               extended_q <= ext_q;
               ext_q      <= 1'b0;
            end
         end
         if (make_key)
            strobe_q <= STB_LOAD;
         else if (strobe_q != '0)
            strobe_q <= strobe_q - SW'(1);
      end
   end

   assign key_if.keycode        = keycode_q;
   assign key_if.extended       = extended_q;
   assign key_if.new_key_strobe = (strobe_q != '0);
   assign key_if.frame_err      = err_q;

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Directed bench for ps2_keycode_receiver; PS/2 bit timing is compressed to HALF clk cycles per phase.
module tb_ps2_keycode_receiver;
   import ps2_keycode_receiver_pkg::*;

   localparam int HALF = 20;
   localparam int TMO  = 25000;

   logic clk_25MHz = 1'b0;
   logic rst_n     = 1'b0;
   logic ps2_clk   = 1'b1;
   logic ps2_data  = 1'b1;

   ps2_keycode_receiver_if kif();

   ps2_keycode_receiver dut (
      .clk_25MHz (clk_25MHz),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_if    (kif)
   );

   always #5 clk_25MHz = ~clk_25MHz;

   int n_assert = 0;
   int n_fail   = 0;
   int strobe_pulses = 0, strobe_cycles = 0, err_pulses = 0, err_cycles = 0;
   int sp0, sc0, ep0, ec0;
   logic strobe_prev = 1'b0, err_prev = 1'b0;

   always @(negedge clk_25MHz) begin
      strobe_prev <= kif.new_key_strobe;
      err_prev    <= kif.frame_err;
      if (kif.new_key_strobe) begin
         strobe_cycles <= strobe_cycles + 1;
         if (!strobe_prev) strobe_pulses <= strobe_pulses + 1;
      end
      if (kif.frame_err) begin
         err_cycles <= err_cycles + 1;
         if (!err_prev) err_pulses <= err_pulses + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      sp0 = strobe_pulses;
      sc0 = strobe_cycles;
      ep0 = err_pulses;
      ec0 = err_cycles;
   endtask

   task automatic ps2_bit(input logic v, input logic glitch);
      ps2_data = v;
      if (glitch) begin
         repeat (HALF/2) @(posedge clk_25MHz);
         ps2_clk = 1'b0;
         repeat (2) @(posedge clk_25MHz);
         ps2_clk = 1'b1;
         repeat (HALF/2 - 2) @(posedge clk_25MHz);
      end else begin
         repeat (HALF) @(posedge clk_25MHz);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk_25MHz);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input int nbits, input int glitch_at);
      logic [10:0] fr;
      fr = {1'b1, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == glitch_at);
      ps2_data = 1'b1;
      repeat (4*HALF) @(posedge clk_25MHz);
      @(negedge clk_25MHz);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, ~^b, 11, -1);
   endtask

   initial begin
      repeat (5) @(posedge clk_25MHz);
      @(negedge clk_25MHz);
      check("rst_keycode", 32'(kif.keycode), 32'h00);
      check("rst_strobe", 32'(kif.new_key_strobe), 32'h0);
      check("rst_extended", 32'(kif.extended), 32'h0);
      check("rst_frame_err", 32'(kif.frame_err), 32'h0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk_25MHz);

      // Plain make code
      snap();
      send_byte(PS2_S);
      check("t1_keycode", 32'(kif.keycode), 32'h1B);
      check("t1_extended", 32'(kif.extended), 32'h0);
      check("t1_strobe_pulses", 32'(strobe_pulses - sp0), 32'd1);
      check("t1_strobe_width", 32'(strobe_cycles - sc0), 32'd1);
      check("t1_no_err", 32'(err_pulses - ep0), 32'd0);

      // Extended make, then a plain make clears extended
      snap();
      send_byte(PS2_EXT);
      send_byte(PS2_UP);
      check("t2_keycode", 32'(kif.keycode), 32'h75);
      check("t2_extended", 32'(kif.extended), 32'h1);
      check("t2_strobe_pulses", 32'(strobe_pulses - sp0), 32'd1);
      send_byte(8'h1D);
      check("t2b_keycode", 32'(kif.keycode), 32'h1D);
      check("t2b_extended", 32'(kif.extended), 32'h0);

      // Press and release: only the press strobes
      snap();
      send_byte(PS2_S);
      send_byte(PS2_BRK);
      send_byte(PS2_S);
      check("t3_strobe_pulses", 32'(strobe_pulses - sp0), 32'd1);
      check("t3_keycode", 32'(kif.keycode), 32'h1B);

      // Bad parity
      snap();
      send_frame(PS2_P, 1'b0, 11, -1);
      check("t4_err_pulses", 32'(err_pulses - ep0), 32'd1);
      check("t4_err_width", 32'(err_cycles - ec0), 32'd1);
      check("t4_no_strobe", 32'(strobe_pulses - sp0), 32'd0);
      check("t4_keycode_held", 32'(kif.keycode), 32'h1B);
      send_byte(PS2_R);
      check("t4b_keycode", 32'(kif.keycode), 32'h2D);

      // Stalled frame: start + 4 data bits, then silence past the timeout
      snap();
      send_frame(8'h0F, 1'b1, 5, -1);
      repeat (TMO + 500) @(posedge clk_25MHz);
      @(negedge clk_25MHz);
      check("t5_tmo_err", 32'(err_pulses - ep0), 32'd1);
      check("t5_tmo_err_width", 32'(err_cycles - ec0), 32'd1);
      check("t5_tmo_no_strobe", 32'(strobe_pulses - sp0), 32'd0);
      send_byte(PS2_ESC);
      check("t5_keycode", 32'(kif.keycode), 32'h76);
      check("t5_extended", 32'(kif.extended), 32'h0);

      // Error after E0 drops the prefix
      snap();
      send_byte(PS2_EXT);
      send_frame(PS2_P, 1'b0, 11, -1);
      send_byte(PS2_UP);
      check("t5b_keycode", 32'(kif.keycode), 32'h75);
      check("t5b_extended", 32'(kif.extended), 32'h0);
      check("t5b_err_pulses", 32'(err_pulses - ep0), 32'd1);
      check("t5b_strobe_pulses", 32'(strobe_pulses - sp0), 32'd1);

      // Short low glitch on ps2_clk mid-frame
      snap();
      send_frame(PS2_DOWN, ~^PS2_DOWN, 11, 4);
      check("t6_glitch_keycode", 32'(kif.keycode), 32'h72);
      check("t6_glitch_no_err", 32'(err_pulses - ep0), 32'd0);
      check("t6_glitch_strobe", 32'(strobe_pulses - sp0), 32'd1);

      // Reset in the middle of a frame
      send_byte(PS2_EXT);
      send_byte(PS2_LEFT);
      check("t6_pre_keycode", 32'(kif.keycode), 32'h6B);
      check("t6_pre_extended", 32'(kif.extended), 32'h1);
      send_frame(PS2_RIGHT, ~^PS2_RIGHT, 4, -1);
      rst_n = 1'b0;
      repeat (3) @(posedge clk_25MHz);
      @(negedge clk_25MHz);
      check("t6_rst_keycode", 32'(kif.keycode), 32'h00);
      check("t6_rst_extended", 32'(kif.extended), 32'h0);
      check("t6_rst_strobe", 32'(kif.new_key_strobe), 32'h0);
      check("t6_rst_frame_err", 32'(kif.frame_err), 32'h0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk_25MHz);
      snap();
      send_byte(PS2_RIGHT);
      check("t6_post_keycode", 32'(kif.keycode), 32'h74);
      check("t6_post_extended", 32'(kif.extended), 32'h0);
      check("t6_post_strobe", 32'(strobe_pulses - sp0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
